// File: rtl/timer_pkg.sv
// Shared types and helpers for the kitchen-timer controller.
//   state_e     : controller FSM state encoding (3 bits, codes 6-7 unused)
//   press_e     : resolved button press, higher encoding wins on collision
//   pick_press  : clear > pause > mode priority resolution
//   cnt_width   : counter width for a counter running 0..n-1
package timer_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StSetMin = 3'd1,
    StSetSec = 3'd2,
    StRun    = 3'd3,
    StPaused = 3'd4,
    StAlarm  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PressNone  = 2'd0,
    PressMode  = 2'd1,
    PressPause = 2'd2,
    PressClear = 2'd3
  } press_e;

  // Coinciding strobes collapse to the single highest-priority press.
  function automatic press_e pick_press(input logic clear, input logic pause, input logic mode);
    if (clear) return PressClear;
    if (pause) return PressPause;
    if (mode)  return PressMode;
    return PressNone;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Front-panel / timer-datapath signal bundle of the controller.
//   slave  : controller side (buttons, switch and done in; timer controls out)
//   master : panel/datapath side (the opposite directions)
interface timer_ctrl_if;
  logic                         btn_mode;
  logic                         btn_pause;
  logic                         btn_clear;
  logic                         dir_up;
  logic                         done;
  logic                         tmr_clock;
  logic                         tmr_up;
  logic                         tmr_reset;
  logic                         tmr_start;
  logic                         tmr_pause;
  logic                         tmr_get_min;
  logic                         tmr_get_sec;
  logic                         alarm;
  logic [timer_pkg::StateW-1:0] state;

  modport slave (
    input  btn_mode, btn_pause, btn_clear, dir_up, done,
    output tmr_clock, tmr_up, tmr_reset, tmr_start, tmr_pause, tmr_get_min, tmr_get_sec,
    output alarm, state
  );

  modport master (
    output btn_mode, btn_pause, btn_clear, dir_up, done,
    input  tmr_clock, tmr_up, tmr_reset, tmr_start, tmr_pause, tmr_get_min, tmr_get_sec,
    input  alarm, state
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability-counter debouncer and a
// one-cycle press strobe on the debounced 0->1 edge.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   btn_i   : raw button level
//   press_o : one-cycle strobe, 2 + DEBOUNCE_CYC + 1 cycles after the raw edge
module btn_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d, level_dly_q, press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) level_d = sync2_q;
      else                 cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// Kitchen-timer controller: debounces the mode/pause/clear buttons, generates
// the count clock and runs the IDLE/SET_MIN/SET_SEC/RUN/PAUSED/ALARM sequence.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : timer_ctrl_if.slave (buttons, dir_up, done in; tmr_* controls,
//           alarm and state out; all outputs registered)
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned ALARM_SEC    = 10
) (
  input logic         clk,
  input logic         reset,
  timer_ctrl_if.slave bus
);
  localparam int unsigned      Period   = CLK_HZ / TICK_HZ;
  localparam int unsigned      TickW    = cnt_width(Period);
  localparam logic [TickW-1:0] TickMax  = TickW'(Period - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(Period / 2);
  localparam int unsigned      AlmW     = cnt_width(ALARM_SEC);
  localparam logic [AlmW-1:0]  AlmMax   = AlmW'(ALARM_SEC - 1);

  logic             press_mode, press_pause, press_clear;
  press_e           press;
  state_e           state_q, state_d;
  logic             start_q, start_d, pause_q, pause_d, rst_q, rst_d, up_q, up_d;
  logic             get_min_q, get_sec_q, alarm_q, tclk_q;
  logic [AlmW-1:0]  alm_cnt_q, alm_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_rise;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .reset(reset), .btn_i(bus.btn_mode), .press_o(press_mode)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
    .clk(clk), .reset(reset), .btn_i(bus.btn_pause), .press_o(press_pause)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clear (
    .clk(clk), .reset(reset), .btn_i(bus.btn_clear), .press_o(press_clear)
  );

  // Count clock: the start pulse re-phases the counter so the first high
  // half-period begins right after start.
  always_comb begin
    if (start_q || tick_cnt_q == TickMax) tick_cnt_d = '0;
    else                                   tick_cnt_d = tick_cnt_q + TickW'(1);
  end

  // A wrap happens on the next edge; a start-forced clear is not a wrap.
  assign tick_rise = (tick_cnt_q == TickMax) && !start_q;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    pause_d   = 1'b0;
    rst_d     = 1'b0;
    up_d      = up_q;
    alm_cnt_d = alm_cnt_q;
    press     = pick_press(press_clear, press_pause, press_mode);

    if (press == PressClear) begin
      state_d = StIdle;
      rst_d   = 1'b1;
    end else begin
      case (state_q)
        StIdle:   if (press == PressMode) state_d = StSetMin;
        StSetMin: if (press == PressMode) state_d = StSetSec;
        StSetSec: begin
          if (press == PressMode) begin
            state_d = StRun;
            start_d = 1'b1;
            up_d    = bus.dir_up;
          end
        end
        StRun: begin
          if (press == PressPause) begin
            state_d = StPaused;
            pause_d = 1'b1;
          end else if (!up_q && bus.done) begin
            state_d   = StAlarm;
            alm_cnt_d = '0;
          end
        end
        StPaused: begin
          if (press == PressPause) begin
            state_d = StRun;
            pause_d = 1'b1;
          end
        end
        StAlarm: begin
          if (press == PressMode) begin
            state_d = StIdle;
            rst_d   = 1'b1;
          end else if (tick_rise) begin
            if (alm_cnt_q == AlmMax) begin
              state_d = StIdle;
              rst_d   = 1'b1;
            end else begin
              alm_cnt_d = alm_cnt_q + AlmW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      rst_q      <= 1'b0;
      up_q       <= 1'b0;
      get_min_q  <= 1'b0;
      get_sec_q  <= 1'b0;
      alarm_q    <= 1'b0;
      alm_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      pause_q    <= pause_d;
      rst_q      <= rst_d;
      up_q       <= up_d;
      get_min_q  <= (state_d == StSetMin);
      get_sec_q  <= (state_d == StSetSec);
      alarm_q    <= (state_d == StAlarm);
      alm_cnt_q  <= alm_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      tclk_q     <= (tick_cnt_d < TickHalf);
    end
  end

  assign bus.tmr_clock   = tclk_q;
  assign bus.tmr_up      = up_q;
  assign bus.tmr_reset   = rst_q;
  assign bus.tmr_start   = start_q;
  assign bus.tmr_pause   = pause_q;
  assign bus.tmr_get_min = get_min_q;
  assign bus.tmr_get_sec = get_sec_q;
  assign bus.alarm       = alarm_q;
  assign bus.state       = state_q;

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- User-facing controller that sequences the kitchen-timer datapath.
- Debounces three front-panel buttons and generates the 1 Hz count clock.
- Runs the setup/run/pause/alarm state machine.
- Drives the timer's control inputs (reset, start, pause, get_min, get_sec, up, clock) and sequences an alarm when the count-down finishes.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1, count-clock frequency; period P = CLK_HZ/TICK_HZ cycles, with P even and ≥ 2.
- DEBOUNCE_CYC, 1_000_000, cycles a synchronized button level must stay stable before it is accepted.
- ALARM_SEC, 10, number of count-clock periods the alarm stays on before auto-clear.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw button: advance setup / start / acknowledge alarm.
- btn_pause  in  1  raw button: pause/resume toggle.
- btn_clear  in  1  raw button: abort to IDLE.
- dir_up  in  1  switch: 1 = count up, 0 = count down.
- done  in  1  timer finished flag (timer led), synchronous to clk.
- tmr_clock  out  1  count clock, 50% duty, period P.
- tmr_up  out  1  direction to timer.
- tmr_reset  out  1  one-cycle timer reset pulse.
- tmr_start  out  1  one-cycle start pulse.
- tmr_pause  out  1  one-cycle pause-toggle pulse.
- tmr_get_min  out  1  level: timer loads minutes from num.
- tmr_get_sec  out  1  level: timer loads seconds from num.
- alarm  out  1  alarm indicator/buzzer enable.
- state  out  3  current FSM state encoding.

Behaviour:
- Reset (reset=0, asynchronous), all outputs: state=IDLE, every pulse/level output 0, tmr_up=0, tmr_clock=0, tick counter 0, debouncers settled at 0.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then the debouncer.
  - The debounced level changes only after DEBOUNCE_CYC consecutive equal samples.
  - A 0→1 transition of the debounced level produces a one-cycle press strobe.
  - Latency from the raw edge to the strobe is 2 + DEBOUNCE_CYC + 1 cycles.
- Tick generator:
  - Counter runs 0..P-1 and wraps.
  - tmr_clock=1 while count < P/2, else 0.
  - Counter is forced to 0 in the cycle tmr_start pulses, so tmr_clock rises in the first cycle after start.
  - tick_rise = counter wrap to 0.
- States: IDLE=0, SET_MIN=1, SET_SEC=2, RUN=3, PAUSED=4, ALARM=5. Codes 6–7 are unreachable and return to IDLE.
- Press priority when strobes coincide in one cycle: clear > pause > mode. Lower-priority strobes in that cycle are dropped.
- clear in any state: go to IDLE, pulse tmr_reset for one cycle, alarm=0.
- IDLE + mode: go to SET_MIN.
- SET_MIN: tmr_get_min=1 for the whole state. On mode: go to SET_SEC.
- SET_SEC: tmr_get_sec=1 for the whole state. On mode: go to RUN, pulse tmr_start, latch tmr_up <= dir_up.
- tmr_get_min and tmr_get_sec are never both high.
- tmr_up stays frozen outside the SET_SEC→RUN transition; dir_up changes during RUN/PAUSED are ignored.
- RUN + pause: go to PAUSED, pulse tmr_pause. PAUSED + pause: go to RUN, pulse tmr_pause.
- Pause strobes in IDLE, SET_MIN, SET_SEC or ALARM are ignored.
- Mode strobes in RUN and PAUSED are ignored.
- RUN, tmr_up=0 and done=1: go to ALARM next cycle and set alarm=1.
- done is ignored in every other state and when tmr_up=1; up-count wraps 59:59→00:00 indefinitely.
- ALARM:
  - alarm=1; count tick_rise events.
  - After ALARM_SEC of them: go to IDLE, pulse tmr_reset, alarm=0.
  - A mode strobe in ALARM does the same immediately (acknowledge).
- tmr_start, tmr_pause and tmr_reset are never asserted in the same cycle.
- Outputs are registered and change one cycle after the causing strobe.
- Reset asserted mid-operation returns everything to reset values immediately. No tmr_reset pulse is generated on reset release.

Decomposition:
- Package timer_pkg holds:
  - state enum and its 3-bit width;
  - press-priority constants;
  - helper function computing counter widths via $clog2 of P and DEBOUNCE_CYC.
- Sub-module btn_debounce (synchronizer + stability counter + rise strobe), parameter DEBOUNCE_CYC, instantiated three times.

Test Plan (CLK_HZ=100, TICK_HZ=10 so P=10, DEBOUNCE_CYC=4, ALARM_SEC=3):
- Reset release, then hold btn_mode high for 3 cycles only → no strobe, state stays 0. Hold for 8 cycles → exactly one strobe 7 cycles after the raw edge, state=1, tmr_get_min=1.
- Mode, mode, mode from IDLE with dir_up=0 → state sequence 1,2,3. tmr_get_sec high only in state 2. One tmr_start pulse. tmr_up=0. tmr_clock high for cycles 1–5 after start, low for 6–10, repeating.
- In RUN press pause twice → states 4 then 3, two single-cycle tmr_pause pulses, no tmr_start.
- In RUN drive done=1 → next cycle state=5, alarm=1. After 3 tmr_clock wraps → state=0, alarm=0, one tmr_reset pulse. Repeat with a mode press during ALARM → immediate return to IDLE.
- Clear and pause strobes in the same cycle while in RUN → state=0, tmr_reset pulsed, no tmr_pause.
- dir_up=1 in RUN with done=1 → state stays 3. Assert reset mid-RUN → all outputs 0 asynchronously, state=0.
